// File: rtl/tlb_unit.sv
// Joint TLB: CP0 TLBWI/TLBR/TLBP access plus registered fetch and data translation ports.
// Unmapped kseg0/kseg1 bypass the entry array; mapped accesses report refill/invalid/mod.
module tlb_unit #(
    parameter int TLB_ENTRIES_NUM = 16,
    parameter int IW = $clog2(TLB_ENTRIES_NUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    tlb_asid,
    input  logic [IW-1:0] tlbrw_index,
    input  logic          tlbrw_we,
    input  logic [77:0]   tlbrw_wdata,
    output logic [77:0]   tlbrw_rdata,
    input  logic [31:0]   tlbp_entry_hi,
    output logic [31:0]   tlbp_index,
    input  logic          kseg0_uncached,
    input  logic          inst_req,
    input  logic [31:0]   inst_vaddr,
    output logic [31:0]   inst_paddr,
    output logic          inst_uncached,
    output logic          inst_refill,
    output logic          inst_invalid,
    input  logic          data_req,
    input  logic [31:0]   data_vaddr,
    input  logic          data_store,
    output logic [31:0]   data_paddr,
    output logic          data_uncached,
    output logic          data_refill,
    output logic          data_invalid,
    output logic          data_mod
);

    typedef struct packed {
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic [7:0]  asid;
        logic [18:0] vpn2;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic        d0;
        logic        v0;
        logic        d1;
        logic        v1;
        logic        g;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        mod;
    } xlate_t;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] idx;
    } hit_t;

    tlb_entry_t                 entries_r [TLB_ENTRIES_NUM];
    logic [TLB_ENTRIES_NUM-1:0] probe_hits_s;
    logic [TLB_ENTRIES_NUM-1:0] inst_hits_s;
    logic [TLB_ENTRIES_NUM-1:0] data_hits_s;
    hit_t                       probe_hit_s;
    hit_t                       inst_hit_s;
    hit_t                       data_hit_s;
    xlate_t                     inst_xlate_s;
    xlate_t                     data_xlate_s;
    logic                       unused_s;

    function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                         input logic [7:0] asid);
        return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    function automatic hit_t first_hit(input logic [TLB_ENTRIES_NUM-1:0] hits);
        hit_t h;
        h = '0;
        for (int i = TLB_ENTRIES_NUM - 1; i >= 0; i--) begin
            h.found = h.found | hits[i];
            h.idx   = hits[i] ? IW'(i) : h.idx;
        end
        return h;
    endfunction

    function automatic xlate_t translate(input logic [31:0] va, input logic store,
                                         input logic hit, input tlb_entry_t e,
                                         input logic k0_uncached);
        xlate_t     r;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        r   = '0;
        pfn = va[12] ? e.pfn1 : e.pfn0;
        c   = va[12] ? e.c1   : e.c0;
        d   = va[12] ? e.d1   : e.d0;
        v   = va[12] ? e.v1   : e.v0;
        case (va[31:29])
            3'b100: begin
                r.paddr    = {3'b000, va[28:0]};
                r.uncached = k0_uncached;
            end
            3'b101: begin
                r.paddr    = {3'b000, va[28:0]};
                r.uncached = 1'b1;
            end
            default: begin
                if (!hit) begin
                    r.refill = 1'b1;
                end else if (!v) begin
                    r.invalid = 1'b1;
                end else if (store && !d) begin
                    r.mod = 1'b1;
                end else begin
                    r.paddr    = {pfn, va[11:0]};
                    r.uncached = (c != 3'd3);
                end
            end
        endcase
        return r;
    endfunction

    // Entry array: cleared on reset, written by TLBWI.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_ENTRIES_NUM; i++) begin
                entries_r[i] <= '0;
            end
        end else if (tlbrw_we) begin
            entries_r[tlbrw_index] <= tlbrw_wdata;
        end
    end

    // Per-entry match vectors for the probe key and both translation ports.
    always_comb begin
        probe_hits_s = '0;
        inst_hits_s  = '0;
        data_hits_s  = '0;
        for (int i = 0; i < TLB_ENTRIES_NUM; i++) begin
            probe_hits_s[i] = entry_match(entries_r[i], tlbp_entry_hi[31:13], tlbp_entry_hi[7:0]);
            inst_hits_s[i]  = entry_match(entries_r[i], inst_vaddr[31:13], tlb_asid);
            data_hits_s[i]  = entry_match(entries_r[i], data_vaddr[31:13], tlb_asid);
        end
    end

    assign probe_hit_s  = first_hit(probe_hits_s);
    assign inst_hit_s   = first_hit(inst_hits_s);
    assign data_hit_s   = first_hit(data_hits_s);
    assign inst_xlate_s = translate(inst_vaddr, 1'b0, inst_hit_s.found,
                                    entries_r[inst_hit_s.idx], kseg0_uncached);
    assign data_xlate_s = translate(data_vaddr, data_store, data_hit_s.found,
                                    entries_r[data_hit_s.idx], kseg0_uncached);

    assign tlbrw_rdata = entries_r[tlbrw_index];
    assign tlbp_index  = probe_hit_s.found ? {{(32 - IW){1'b0}}, probe_hit_s.idx}
                                           : 32'h8000_0000;
    // Probe key bits between VPN2 and ASID, and the fetch-side mod flag, are don't-care.
    assign unused_s    = ^{tlbp_entry_hi[12:8], inst_xlate_s.mod};

    // Fetch translation register: loads on request, holds otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_paddr    <= 32'h0000_0000;
            inst_uncached <= 1'b0;
            inst_refill   <= 1'b0;
            inst_invalid  <= 1'b0;
        end else if (inst_req) begin
            inst_paddr    <= inst_xlate_s.paddr;
            inst_uncached <= inst_xlate_s.uncached;
            inst_refill   <= inst_xlate_s.refill;
            inst_invalid  <= inst_xlate_s.invalid;
        end
    end

    // Data translation register: loads on request, holds otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_paddr    <= 32'h0000_0000;
            data_uncached <= 1'b0;
            data_refill   <= 1'b0;
            data_invalid  <= 1'b0;
            data_mod      <= 1'b0;
        end else if (data_req) begin
            data_paddr    <= data_xlate_s.paddr;
            data_uncached <= data_xlate_s.uncached;
            data_refill   <= data_xlate_s.refill;
            data_invalid  <= data_xlate_s.invalid;
            data_mod      <= data_xlate_s.mod;
        end
    end

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: lookups push expected results, a negedge monitor pops and compares.
module tb_tlb_unit;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        mod;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  tlb_asid;
    logic [3:0]  tlbrw_index;
    logic        tlbrw_we;
    logic [77:0] tlbrw_wdata;
    logic [77:0] tlbrw_rdata;
    logic [31:0] tlbp_entry_hi;
    logic [31:0] tlbp_index;
    logic        kseg0_uncached;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic [31:0] inst_paddr;
    logic        inst_uncached;
    logic        inst_refill;
    logic        inst_invalid;
    logic        data_req;
    logic [31:0] data_vaddr;
    logic        data_store;
    logic [31:0] data_paddr;
    logic        data_uncached;
    logic        data_refill;
    logic        data_invalid;
    logic        data_mod;

    int   checks = 0;
    int   failures = 0;
    exp_t dq[$];
    exp_t iq[$];
    logic data_pend = 1'b0;
    logic inst_pend = 1'b0;

    logic [77:0] e1, e2, e3;

    tlb_unit #(.TLB_ENTRIES_NUM(16)) dut (
        .clk(clk), .resetn(resetn), .tlb_asid(tlb_asid),
        .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
        .kseg0_uncached(kseg0_uncached),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr),
        .inst_uncached(inst_uncached), .inst_refill(inst_refill), .inst_invalid(inst_invalid),
        .data_req(data_req), .data_vaddr(data_vaddr), .data_store(data_store),
        .data_paddr(data_paddr), .data_uncached(data_uncached), .data_refill(data_refill),
        .data_invalid(data_invalid), .data_mod(data_mod)
    );

    always #5 clk = ~clk;

    function automatic logic [77:0] mk(input logic [2:0] c0, input logic [2:0] c1,
                                       input logic [7:0] asid, input logic [18:0] vpn2,
                                       input logic [19:0] pfn0, input logic [19:0] pfn1,
                                       input logic d0, input logic v0, input logic d1,
                                       input logic v1, input logic g);
        return {c0, c1, asid, vpn2, pfn0, pfn1, d0, v0, d1, v1, g};
    endfunction

    function automatic exp_t ok(input logic [31:0] pa, input logic unc);
        return {pa, unc, 1'b0, 1'b0, 1'b0};
    endfunction

    localparam exp_t REFILL  = {32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam exp_t INVALID = {32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam exp_t MODX    = {32'h0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_write(input logic [3:0] idx, input logic [77:0] e);
        tlbrw_we = 1'b1;
        tlbrw_index = idx;
        tlbrw_wdata = e;
    endtask

    task automatic set_data(input logic [31:0] va, input logic st, input exp_t e);
        data_req = 1'b1;
        data_vaddr = va;
        data_store = st;
        dq.push_back(e);
    endtask

    task automatic set_inst(input logic [31:0] va, input exp_t e);
        inst_req = 1'b1;
        inst_vaddr = va;
        iq.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        data_req = 1'b0;
        inst_req = 1'b0;
        tlbrw_we = 1'b0;
        data_store = 1'b0;
    endtask

    // A request sampled at a clock edge outside reset produces a result the next half cycle.
    always @(posedge clk) begin
        data_pend <= data_req && resetn;
        inst_pend <= inst_req && resetn;
    end

    // Monitor: pop expected results and compare against the registered outputs.
    always @(negedge clk) begin
        exp_t e;
        if (data_pend) begin
            if (dq.size() == 0) begin
                chk("data_unexpected", 128'd1, 128'd0);
            end else begin
                e = dq.pop_front();
                chk("data_xlate", {data_paddr, data_uncached, data_refill, data_invalid, data_mod}, e);
            end
        end
        if (inst_pend) begin
            if (iq.size() == 0) begin
                chk("inst_unexpected", 128'd1, 128'd0);
            end else begin
                e = iq.pop_front();
                chk("inst_xlate", {inst_paddr, inst_uncached, inst_refill, inst_invalid, 1'b0}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        e1 = mk(3'd3, 3'd2, 8'h05, 19'h00040, 20'h12345, 20'h0ABCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e2 = mk(3'd3, 3'd2, 8'h05, 19'h00040, 20'h12345, 20'h0ABCD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        e3 = mk(3'd3, 3'd0, 8'h00, 19'h00040, 20'h55555, 20'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        resetn = 1'b0;
        tlb_asid = 8'h05;
        tlbrw_index = 4'd3;
        tlbrw_we = 1'b0;
        tlbrw_wdata = 78'h0;
        tlbp_entry_hi = 32'h0008_0005;
        kseg0_uncached = 1'b0;
        inst_req = 1'b0;
        inst_vaddr = 32'h0;
        data_req = 1'b0;
        data_vaddr = 32'h0;
        data_store = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_inst_paddr", inst_paddr, 32'h0);
        chk("rst_data_paddr", data_paddr, 32'h0);
        chk("rst_flags", {inst_uncached, inst_refill, inst_invalid, data_uncached,
                          data_refill, data_invalid, data_mod}, 7'h0);
        chk("rst_rdata", tlbrw_rdata, 78'h0);
        chk("rst_probe", tlbp_index, 32'h8000_0000);
        resetn = 1'b1;

        set_write(4'd3, e1);
        tick();
        set_data(32'h0008_0ABC, 1'b0, ok(32'h1234_5ABC, 1'b0));
        tick();
        tlb_asid = 8'h06;
        set_data(32'h0008_0ABC, 1'b0, REFILL);
        tick();

        tlb_asid = 8'h05;
        tlbp_entry_hi = 32'h0008_0005;
        tlbrw_index = 4'd3;
        #1;
        chk("probe_hit", tlbp_index, 32'h0000_0003);
        chk("tlbr_read", tlbrw_rdata, e1);
        tlbp_entry_hi = 32'hFFFF_E005;
        #1;
        chk("probe_miss", tlbp_index, 32'h8000_0000);

        set_data(32'h0008_1000, 1'b0, INVALID);
        tick();

        // Rewrite with G = 1 while a lookup with a foreign ASID sees the old entry.
        tlb_asid = 8'h06;
        set_write(4'd3, e2);
        set_data(32'h0008_0ABC, 1'b0, REFILL);
        #1;
        chk("tlbr_prewrite", tlbrw_rdata, e1);
        tick();
        set_data(32'h0008_0ABC, 1'b0, ok(32'h1234_5ABC, 1'b0));
        tick();
        set_data(32'h0008_1000, 1'b1, MODX);
        tick();
        set_data(32'h0008_1000, 1'b0, ok(32'h0ABC_D000, 1'b1));
        tick();

        kseg0_uncached = 1'b0;
        set_inst(32'h9FC0_0000, ok(32'h1FC0_0000, 1'b0));
        set_data(32'h8000_1234, 1'b1, ok(32'h0000_1234, 1'b0));
        tick();
        kseg0_uncached = 1'b1;
        set_inst(32'h9FC0_0000, ok(32'h1FC0_0000, 1'b1));
        tick();
        kseg0_uncached = 1'b0;
        set_inst(32'hBFC0_0000, ok(32'h1FC0_0000, 1'b1));
        set_data(32'hBFC0_0004, 1'b0, ok(32'h1FC0_0004, 1'b1));
        tick();
        set_inst(32'h0008_0123, ok(32'h1234_5123, 1'b0));
        tick();
        inst_vaddr = 32'h0000_0000;
        tick();
        chk("inst_hold", {inst_paddr, inst_uncached, inst_refill, inst_invalid},
            {32'h1234_5123, 3'b000});

        set_write(4'd1, e3);
        tick();
        tlbp_entry_hi = 32'h0008_0005;
        #1;
        chk("probe_lowest", tlbp_index, 32'h0000_0001);
        set_data(32'h0008_0ABC, 1'b0, ok(32'h5555_5ABC, 1'b0));
        tick();

        // Reset with a request pending: it is dropped and the array is cleared.
        resetn = 1'b0;
        data_req = 1'b1;
        data_vaddr = 32'h0008_0ABC;
        inst_req = 1'b1;
        inst_vaddr = 32'h0008_0123;
        tick();
        resetn = 1'b1;
        chk("rst2_data", {data_paddr, data_uncached, data_refill, data_invalid, data_mod}, 36'h0);
        chk("rst2_inst", {inst_paddr, inst_uncached, inst_refill, inst_invalid}, 35'h0);
        tlbrw_index = 4'd3;
        #1;
        chk("rst2_rdata", tlbrw_rdata, 78'h0);
        tlb_asid = 8'h05;
        set_data(32'h0008_0ABC, 1'b0, REFILL);
        tick();
        tick();
        tick();
        chk("data_queue_drained", dq.size(), 0);
        chk("inst_queue_drained", iq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
